// File: rtl/rsc2_dec_lextr.sv
// rsc2_dec_lextr
// Extrinsic LLR extractor for the duobit RSC2 decoder. The a-priori LLRs and
// frame tags that accompanied a symbol into the upstream a-posteriori unit are
// delayed by pDELAY enabled cycles. When the matching a-posteriori word arrives
// (iLapo_val), the a-priori part is removed, optionally scaled, saturated and
// presented together with a hard duobit decision and a per-frame symbol index.
//
// Optional feature (macro RSC2_DEC_LEXTR_SCALE_EN):
//   defined   : extrinsic = d - (d >>> 2)   (0.75 scaling)
//   undefined : extrinsic = d               (unity)
//   Latency is two enabled cycles from iLapo_val in both builds.
//
// Ports:
//   iclk, ireset, iclkena      clock, async active-high reset, clock enable
//   ival, isop, ieop, iLapri   a-priori valid/tags/LLRs (symbols 1..3 vs 0)
//   iLapo_val, iLapo           a-posteriori valid and LLRs (symbols 1..3)
//   oval, osop, oeop           output valid and frame tags
//   oaddr                      symbol index within the frame
//   oLextr                     saturated extrinsic LLRs (symbols 1..3)
//   odat                       hard duobit decision
//   oalign_err                 sticky iLapo_val / delayed ival mismatch flag
module rsc2_dec_lextr #(
  parameter int pLLR_W  = 5,
  parameter int pLAPO_W = 9,
  parameter int pEXTR_W = 7,
  parameter int pDELAY  = 6,
  parameter int pADDR_W = 10
) (
  input  logic                              iclk,
  input  logic                              ireset,
  input  logic                              iclkena,
  input  logic                              ival,
  input  logic                              isop,
  input  logic                              ieop,
  input  logic [2:0][pLLR_W-1:0]            iLapri,
  input  logic                              iLapo_val,
  input  logic [2:0][pLAPO_W-1:0]           iLapo,
  output logic                              oval,
  output logic                              osop,
  output logic                              oeop,
  output logic [pADDR_W-1:0]                oaddr,
  output logic [2:0][pEXTR_W-1:0]           oLextr,
  output logic [1:0]                        odat,
  output logic                              oalign_err
);

  // One guard bit over the a-posteriori width keeps the subtraction exact.
  localparam int cD_W = pLAPO_W + 1;
  localparam logic signed [cD_W-1:0] cSAT_HI = cD_W'((2 ** (pEXTR_W - 1)) - 1);
  localparam logic signed [cD_W-1:0] cSAT_LO = -cSAT_HI;

  logic [pDELAY-1:0]        dly_val;
  logic [pDELAY-1:0]        dly_sop;
  logic [pDELAY-1:0]        dly_eop;
  logic [2:0][pLLR_W-1:0]   dly_lapri [pDELAY];

  logic                     dl_val;
  logic                     dl_sop;
  logic                     dl_eop;
  logic [2:0][pLLR_W-1:0]   dl_lapri;

  logic signed [cD_W-1:0]   diff   [3];
  logic signed [cD_W-1:0]   scaled [3];
  logic signed [pLAPO_W-1:0] best;
  logic [1:0]               hard;

  logic                     s1_val;
  logic                     s1_sop;
  logic                     s1_eop;
  logic signed [cD_W-1:0]   s1_d [3];
  logic [1:0]               s1_dat;

  logic [2:0][pEXTR_W-1:0]  sat;

  // The delay line shifts on every enabled cycle, idle or not, so that its
  // tap lines up with the fixed latency of the upstream a-posteriori unit.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      dly_val <= '0;
      dly_sop <= '0;
      dly_eop <= '0;
      for (int k = 0; k < pDELAY; k++) dly_lapri[k] <= '0;
    end else if (iclkena) begin
      dly_val[0]   <= ival;
      dly_sop[0]   <= isop;
      dly_eop[0]   <= ieop;
      dly_lapri[0] <= iLapri;
      for (int k = 1; k < pDELAY; k++) begin
        dly_val[k]   <= dly_val[k-1];
        dly_sop[k]   <= dly_sop[k-1];
        dly_eop[k]   <= dly_eop[k-1];
        dly_lapri[k] <= dly_lapri[k-1];
      end
    end
  end

  assign dl_val   = dly_val[pDELAY-1];
  assign dl_sop   = dly_sop[pDELAY-1];
  assign dl_eop   = dly_eop[pDELAY-1];
  assign dl_lapri = dly_lapri[pDELAY-1];

  // Extrinsic difference and hard decision. Symbol 0 is the implicit zero
  // reference, so the argmax starts from 0 and only a strictly larger LLR
  // moves it, which gives ties to the lowest index.
  always_comb begin
    best = '0;
    hard = 2'd0;
    for (int i = 0; i < 3; i++) begin
      diff[i] = $signed({iLapo[i][pLAPO_W-1], iLapo[i]})
              - $signed({{(cD_W - pLLR_W){dl_lapri[i][pLLR_W-1]}}, dl_lapri[i]});
`ifdef RSC2_DEC_LEXTR_SCALE_EN
      scaled[i] = diff[i] - (diff[i] >>> 2);
`else
      scaled[i] = diff[i];
`endif
      if ($signed(iLapo[i]) > best) begin
        best = $signed(iLapo[i]);
        hard = 2'(i + 1);
      end
    end
  end

  // Stage 1 captures the scaled differences. The output path follows
  // iLapo_val even when it disagrees with the delayed ival.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      s1_val <= 1'b0;
      s1_sop <= 1'b0;
      s1_eop <= 1'b0;
      s1_dat <= '0;
      for (int i = 0; i < 3; i++) s1_d[i] <= '0;
    end else if (iclkena) begin
      s1_val <= iLapo_val;
      if (iLapo_val) begin
        s1_sop <= dl_sop;
        s1_eop <= dl_eop;
        s1_dat <= hard;
        for (int i = 0; i < 3; i++) s1_d[i] <= scaled[i];
      end
    end
  end

  // Symmetric saturation so the most negative code is never produced.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      if (s1_d[i] > cSAT_HI) begin
        sat[i] = cSAT_HI[pEXTR_W-1:0];
      end else if (s1_d[i] < cSAT_LO) begin
        sat[i] = cSAT_LO[pEXTR_W-1:0];
      end else begin
        sat[i] = s1_d[i][pEXTR_W-1:0];
      end
    end
  end

  // Stage 2: output register. Data and address only update on a valid
  // symbol so they hold between outputs.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      oval   <= 1'b0;
      osop   <= 1'b0;
      oeop   <= 1'b0;
      oaddr  <= '0;
      oLextr <= '0;
      odat   <= '0;
    end else if (iclkena) begin
      oval <= s1_val;
      osop <= s1_val & s1_sop;
      oeop <= s1_val & s1_eop;
      if (s1_val) begin
        oLextr <= sat;
        odat   <= s1_dat;
        oaddr  <= s1_sop ? '0 : oaddr + pADDR_W'(1);
      end
    end
  end

  // Sticky flag: the a-posteriori stream has drifted from the delay line.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      oalign_err <= 1'b0;
    end else if (iclkena && (iLapo_val != dl_val)) begin
      oalign_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rsc2_dec_lextr.sv
// tb_rsc2_dec_lextr
// Scoreboard bench for rsc2_dec_lextr. The driver issues a-priori symbols and
// replays the matching a-posteriori word pDELAY enabled cycles later; when it
// drives that word it pushes the hand-computed expected output. A monitor pops
// and compares whenever the DUT presents oval after an enabled edge.
// Expected values follow the RSC2_DEC_LEXTR_SCALE_EN setting of the build.
module tb_rsc2_dec_lextr;

  localparam int cDELAY = 6;

  logic             iclk = 1'b0;
  logic             ireset;
  logic             iclkena;
  logic             ival;
  logic             isop;
  logic             ieop;
  logic [2:0][4:0]  iLapri;
  logic             iLapo_val;
  logic [2:0][8:0]  iLapo;
  logic             oval;
  logic             osop;
  logic             oeop;
  logic [9:0]       oaddr;
  logic [2:0][6:0]  oLextr;
  logic [1:0]       odat;
  logic             oalign_err;

  rsc2_dec_lextr dut (
    .iclk       (iclk),
    .ireset     (ireset),
    .iclkena    (iclkena),
    .ival       (ival),
    .isop       (isop),
    .ieop       (ieop),
    .iLapri     (iLapri),
    .iLapo_val  (iLapo_val),
    .iLapo      (iLapo),
    .oval       (oval),
    .osop       (osop),
    .oeop       (oeop),
    .oaddr      (oaddr),
    .oLextr     (oLextr),
    .odat       (odat),
    .oalign_err (oalign_err)
  );

  always #5 iclk = ~iclk;

  // Directed vectors: a-priori, a-posteriori, hand-computed extrinsic and
  // hard decision (lane 0 is symbol 1).
  int vec_lapri [9][3] = '{'{2,-1,0}, '{0,0,0}, '{0,0,0}, '{-16,15,3}, '{5,5,5},
                           '{0,0,-16}, '{1,2,3}, '{-16,-16,-16}, '{0,0,0}};
  int vec_lapo  [9][3] = '{'{22,5,-3}, '{200,-200,-256}, '{-5,-5,-1}, '{10,30,30},
                           '{-100,60,-7}, '{0,0,47}, '{0,0,0}, '{255,-256,48},
                           '{-64,-63,64}};
`ifdef RSC2_DEC_LEXTR_SCALE_EN
  int vec_lextr [9][3] = '{'{15,5,-2}, '{63,-63,-63}, '{-3,-3,0}, '{20,12,21},
                           '{-63,42,-9}, '{0,0,48}, '{0,-1,-2}, '{63,-63,48},
                           '{-48,-47,48}};
`else
  int vec_lextr [9][3] = '{'{20,6,-3}, '{63,-63,-63}, '{-5,-5,-1}, '{26,15,27},
                           '{-63,55,-12}, '{0,0,63}, '{-1,-2,-3}, '{63,-63,63},
                           '{-63,-63,63}};
`endif
  int vec_dat [9] = '{1, 1, 0, 2, 2, 3, 0, 1, 3};

  typedef struct {
    logic v;
    logic sop;
    logic eop;
    int   vec;
  } pipe_t;

  typedef struct {
    int   lextr [3];
    int   dat;
    int   addr;
    logic sop;
    logic eop;
  } exp_t;

  pipe_t pipe [$];
  exp_t  sb [$];
  int    model_addr;
  int    checks;
  int    errors;
  int    out_count;
  int    saved_count;

  logic  mon_en;
  logic  mon_rst;
  exp_t  mon_e;

  function automatic pipe_t idle_entry();
    pipe_t e;
    e.v   = 1'b0;
    e.sop = 1'b0;
    e.eop = 1'b0;
    e.vec = 0;
    return e;
  endfunction

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One clock of stimulus. With en=0 all inputs hold and the bench's own
  // a-posteriori pipe does not advance, mirroring the DUT.
  task automatic apply_stimulus(input logic en, input logic v, input logic sop,
                                input logic eop, input int vec);
    pipe_t e;
    pipe_t p;
    exp_t  x;
    @(negedge iclk);
    iclkena = en;
    if (en) begin
      e.v = v; e.sop = sop; e.eop = eop; e.vec = vec;
      pipe.push_back(e);
      p = pipe.pop_front();
      ival = v;
      isop = v & sop;
      ieop = v & eop;
      for (int i = 0; i < 3; i++) iLapri[i] = v ? 5'(vec_lapri[vec][i]) : 5'd0;
      iLapo_val = p.v;
      for (int i = 0; i < 3; i++) iLapo[i] = p.v ? 9'(vec_lapo[p.vec][i]) : 9'd0;
      if (p.v) begin
        model_addr = p.sop ? 0 : (model_addr + 1) % 1024;
        for (int i = 0; i < 3; i++) x.lextr[i] = vec_lextr[p.vec][i];
        x.dat  = vec_dat[p.vec];
        x.addr = model_addr;
        x.sop  = p.sop;
        x.eop  = p.eop;
        sb.push_back(x);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic do_reset();
    @(negedge iclk);
    ireset    = 1'b1;
    iclkena   = 1'b1;
    ival      = 1'b0;
    isop      = 1'b0;
    ieop      = 1'b0;
    iLapri    = '0;
    iLapo_val = 1'b0;
    iLapo     = '0;
    pipe.delete();
    repeat (cDELAY) pipe.push_back(idle_entry());
    model_addr = 0;
    @(negedge iclk);
    ireset = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      idle(1);
      n++;
    end
    check_output("drain_pending", sb.size(), 0);
  endtask

  // Monitor: an output counts when oval is high after an enabled edge.
  always @(posedge iclk) begin
    mon_en  = iclkena;
    mon_rst = ireset;
    #1;
    if (!mon_rst && mon_en && oval) begin
      out_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_oval actual=1 expected=0 addr=%0d", oaddr);
      end else begin
        mon_e = sb.pop_front();
        for (int i = 0; i < 3; i++)
          check_output($sformatf("lextr%0d", i + 1), int'($signed(oLextr[i])), mon_e.lextr[i]);
        check_output("odat", int'(odat), mon_e.dat);
        check_output("oaddr", int'(oaddr), mon_e.addr);
        check_output("osop", int'(osop), int'(mon_e.sop));
        check_output("oeop", int'(oeop), int'(mon_e.eop));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    out_count = 0;
    ireset    = 1'b0;
    iclkena   = 1'b1;
    ival      = 1'b0;
    isop      = 1'b0;
    ieop      = 1'b0;
    iLapri    = '0;
    iLapo_val = 1'b0;
    iLapo     = '0;

    do_reset();
    check_output("rst_oval", int'(oval), 0);
    check_output("rst_osop", int'(osop), 0);
    check_output("rst_oeop", int'(oeop), 0);
    check_output("rst_oaddr", int'(oaddr), 0);
    check_output("rst_oLextr", int'(oLextr), 0);
    check_output("rst_odat", int'(odat), 0);
    check_output("rst_align", int'(oalign_err), 0);

    // Four-symbol frame, then a one-symbol frame.
    apply_stimulus(1, 1, 1, 0, 0);
    apply_stimulus(1, 1, 0, 0, 1);
    apply_stimulus(1, 1, 0, 0, 2);
    apply_stimulus(1, 1, 0, 1, 3);
    idle(2);
    apply_stimulus(1, 1, 1, 1, 4);
    idle(1);

    // Frame with gaps and clock-enable stalls, both upstream and in flight.
    apply_stimulus(1, 1, 1, 0, 5);
    apply_stimulus(0, 0, 0, 0, 0);
    apply_stimulus(1, 1, 0, 0, 6);
    apply_stimulus(1, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    apply_stimulus(1, 1, 0, 0, 7);
    apply_stimulus(1, 1, 0, 1, 8);
    idle(4);
    apply_stimulus(0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    idle(10);
    drain();
    check_output("align_clean", int'(oalign_err), 0);

    // Reset while symbols are still inside the delay line.
    apply_stimulus(1, 1, 1, 0, 0);
    apply_stimulus(1, 1, 0, 0, 1);
    apply_stimulus(1, 1, 0, 0, 2);
    idle(2);
    saved_count = out_count;
    do_reset();
    idle(15);
    check_output("no_oval_after_reset", out_count, saved_count);
    check_output("sb_empty_after_reset", sb.size(), 0);

    // Clean one-symbol frame, then a symbol whose a-posteriori word is early.
    apply_stimulus(1, 1, 1, 1, 0);
    idle(cDELAY + 4);
    drain();
    check_output("align_before_early", int'(oalign_err), 0);
    void'(pipe.pop_front());
    apply_stimulus(1, 1, 0, 0, 2);
    idle(cDELAY + 4);
    pipe.push_front(idle_entry());
    apply_stimulus(1, 1, 0, 1, 3);
    idle(cDELAY + 4);
    drain();
    check_output("align_set", int'(oalign_err), 1);
    idle(5);
    check_output("align_held", int'(oalign_err), 1);
    do_reset();
    check_output("align_cleared", int'(oalign_err), 0);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsc2_dec_lextr.md
RSC2_DEC_LEXTR -- requirements
Module: rsc2_dec_lextr

Interface
REQ-001 SHALL have parameter pLLR_W, default 5, signed width of each a-priori duobit LLR.
REQ-002 SHALL have parameter pLAPO_W, default 9, signed width of each a-posteriori LLR from rsc2_dec_Lapo.
REQ-003 SHALL have parameter pEXTR_W, default 7, signed width of each extrinsic output LLR.
REQ-004 SHALL have parameter pDELAY, default 6, cycles from ival to the matching iLapo_val, equal to rsc2_dec_Lapo ival-to-oval latency.
REQ-005 SHALL have parameter pADDR_W, default 10, width of the output symbol address.
REQ-006 SHALL have port iclk  in  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port ireset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port iclkena  in  1  clock enable; when 0, all state holds.
REQ-009 SHALL have ports ival / isop / ieop  in  1 each  a-priori valid, start-of-frame, end-of-frame, issued with the gamma entering upstream.
REQ-010 SHALL have port iLapri  in  3 x pLLR_W  signed a-priori LLRs for duobit symbols 1..3, relative to symbol 0.
REQ-011 SHALL have port iLapo_val  in  1  valid from rsc2_dec_Lapo oval.
REQ-012 SHALL have port iLapo  in  3 x pLAPO_W  signed a-posteriori LLRs, symbols 1..3.
REQ-013 SHALL have ports oval / osop / oeop  out  1 each  output valid and frame tags.
REQ-014 SHALL have port oaddr  out  pADDR_W  symbol index within frame.
REQ-015 SHALL have port oLextr  out  3 x pEXTR_W  signed extrinsic LLRs.
REQ-016 SHALL have port odat  out  2  hard duobit decision.
REQ-017 SHALL have port oalign_err  out  1  sticky alignment error flag.

Function
REQ-018 SHALL delay {ival, isop, ieop, iLapri} by a pDELAY-deep shift register, advancing only when iclkena=1, shifting every enabled cycle regardless of ival.
REQ-019 Stage 1, on iclkena & iLapo_val: d[i] = iLapo[i] - delayed iLapri[i] (sign-extended, pLAPO_W+1 bits), then scaled per REQ-029.
REQ-020 Stage 1 SHALL also compute odat = index of max over {0, iLapo[1], iLapo[2], iLapo[3]}; ties go to the lowest index.
REQ-021 Stage 2 SHALL saturate each scaled d[i] symmetrically to ±(2^(pEXTR_W-1)-1) and register it into oLextr.
REQ-022 oval SHALL assert exactly 2 enabled cycles after iLapo_val; osop/oeop SHALL be the delayed tags carried alongside it.
REQ-023 oLextr, odat and oaddr SHALL hold their values while oval=0.
REQ-024 oaddr SHALL be 0 on an oval with osop=1, increment by 1 on each further oval, and wrap from 2^pADDR_W-1 to 0.
REQ-025 If osop and oeop are both set (one-symbol frame), oaddr SHALL be 0 and the next osop SHALL restart at 0.
REQ-026 If iLapo_val differs from the delayed ival on any enabled cycle, oalign_err SHALL set and stay set until ireset; the output path still follows iLapo_val, using the delayed iLapri as-is.

Reset
REQ-027 ireset=1 SHALL asynchronously clear the delay line valid/tag bits, the stage valids, oval, osop, oeop, oaddr, oalign_err, oLextr and odat to 0.
REQ-028 Reset mid-frame SHALL discard all in-flight symbols; no oval SHALL be produced for them after reset releases.

Configuration
REQ-029 With macro RSC2_DEC_LEXTR_SCALE_EN defined, the scaled value SHALL be d - (d>>>2) (0.75 scaling, arithmetic shift); without it, the scaled value SHALL be d (unity), with no extra latency in either case.

Verification
REQ-030 iLapri=(2,-1,0), iLapo=(22,5,-3) pDELAY cycles later, SCALE_EN off -> 2 cycles later oval=1, oLextr=(20,6,-3), odat=1.
REQ-031 Same stimulus, SCALE_EN on -> oLextr=(15,5,-2), odat=1.
REQ-032 iLapri=0, iLapo=(200,-200,-256) -> oLextr=(63,-63,-63), odat=1; iLapo=(-5,-5,-1) -> odat=0.
REQ-033 Frame of 4 symbols (isop on 1st, ieop on 4th), then a 1-symbol frame -> oaddr 0,1,2,3 then 0; osop/oeop aligned with the first and last oval.
REQ-034 iLapo_val asserted one cycle early -> oalign_err=1 and held until ireset; toggling iclkena=0 mid-stream only stretches timing, with identical output values.
